cpx_pkt_serializer: RTL and testbench
=====================================

Name: cpx_pkt_serializer

Overview:
- Generalised CPX-to-host serializer.
- Accepts whole CPX packets of PKT_WORDS 32-bit words through a valid/ready handshake and buffers them in a FIFO_DEPTH-entry packet FIFO.
- Emits each packet as a fixed-length frame of FRAME_CHUNKS 64-bit chunks to the host stream interface. Each chunk is {32-bit header, 32-bit payload}.
- Sits between the CCX CPX output and the host-side stream read port. The host pulls one chunk per asserted chunk_read.

Parameters:
- PKT_WORDS, 5: 32-bit words per CPX packet. Must be ≥ 1.
- FIFO_DEPTH, 4: packet FIFO entries. Must be a power of 2, ≥ 2.
- FRAME_CHUNKS, 8: chunks per emitted frame. Must be ≥ PKT_WORDS. Chunks beyond PKT_WORDS are padding.
- HDR_FIRST, 32'h00000018: header of chunk 0.
- HDR_MID, 32'h00000010: header of chunks 1..PKT_WORDS-1.
- HDR_PAD, 32'h00000000: header of padding chunks.
- PAD_WORD, 32'h0BAD0BAD: payload of padding chunks.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pkt_valid  in  1  packet offered
- pkt_ready  out  1  FIFO can accept a packet
- pkt_data  in  32*PKT_WORDS  packet; word 0 = MSBs
- chunk_read  in  1  host consumes current chunk
- chunk  out  64  current chunk
- chunk_empty  out  1  no chunk available
- pkt_sent  out  1  one-cycle pulse: a frame was fully consumed
- fifo_count  out  $clog2(FIFO_DEPTH)+1  packets buffered, including the one in transmission
- frames_sent  out  16  wrapping count of completed frames

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO pointers, fifo_count and chunk index clear to 0.
  - pkt_sent and frames_sent clear to 0.
  - Reset mid-frame discards the partial frame and all buffered packets. No pkt_sent is generated.
  - After reset: pkt_ready=1, chunk_empty=1.
- Push:
  - pkt_ready = (fifo_count != FIFO_DEPTH), combinational.
  - A push occurs on a clk edge with pkt_valid & pkt_ready. pkt_data is written at the write pointer and the write pointer wraps modulo FIFO_DEPTH.
  - pkt_valid while full is ignored (no write, no overwrite).
- Output:
  - chunk_empty = (fifo_count == 0).
  - chunk is combinational from the FIFO head entry and chunk index idx (0..FRAME_CHUNKS-1):
    - idx=0: {HDR_FIRST, word 0}
    - 1 ≤ idx < PKT_WORDS: {HDR_MID, word idx}
    - PKT_WORDS ≤ idx < FRAME_CHUNKS: {HDR_PAD, PAD_WORD}
  - While chunk_empty=1, chunk = {HDR_PAD, PAD_WORD}.
- Advance:
  - On a clk edge with chunk_read & !chunk_empty:
    - If idx < FRAME_CHUNKS-1: idx increments.
    - Else: idx returns to 0, the head is popped (read pointer wraps), pkt_sent=1 for exactly the next cycle, and frames_sent increments (wraps at 2^16).
  - chunk_read while chunk_empty=1 is ignored: no index change, no pulse.
- Simultaneous push and pop in one cycle: fifo_count unchanged, both pointers advance.
  - At full, a push is only possible if pkt_ready was already 1, so a same-cycle pop does not admit the push. This keeps pkt_ready free of combinational paths to chunk_read.
- Latency:
  - A packet pushed into an empty FIFO presents chunk 0 in the cycle after the push edge.
  - Minimum frame duration is FRAME_CHUNKS cycles.
  - Back-to-back frames have no gap when chunk_read is held high.
- The head entry is stable for the whole frame. A new push never alters the frame in transmission.
- FRAME_CHUNKS == PKT_WORDS gives frames with no padding.

Decomposition:
- Shared package cpx_host_pkg holds:
  - CPX_HDR_FIRST, CPX_HDR_MID, CPX_HDR_PAD, CPX_PAD_WORD constants
  - CPX_WORD_W = 32 and CHUNK_W = 64
- One sub-module: pkt_fifo, a generic DEPTH×WIDTH synchronous FIFO with count, head read port and push/pop.
- Chunk mux, index counter and pulse logic live in the top module.

Test Plan:
1. Reset, then push one packet A0..A4 = 0x11111111..0x55555555, chunk_read held 1:
   - chunks 0x00000018_11111111, 0x00000010_22222222 … 0x00000010_55555555, then 3× 0x00000000_0BAD0BAD
   - pkt_sent pulses once after chunk 7; frames_sent=1; chunk_empty=1 afterwards.
2. Push 4 packets with chunk_read=0:
   - pkt_ready=0 and fifo_count=4.
   - A 5th pkt_valid is dropped.
   - Drain all: exactly 4 frames (32 chunks) with data in push order, and 4 pkt_sent pulses.
3. chunk_read toggled 1-0-1-0 during a frame:
   - idx advances only on 1-cycles; the frame content matches scenario 1 with no duplicates or skips.
4. With the FIFO full, pop the final chunk while pkt_valid=1:
   - no push that cycle; the next cycle pkt_ready=1 and the push succeeds; fifo_count reads 4→3→4.
5. Assert rst at idx=3 with 2 packets buffered:
   - next cycle fifo_count=0, chunk_empty=1, no pkt_sent.
   - A new packet then starts at the HDR_FIRST chunk.
6. Parameters PKT_WORDS=3, FRAME_CHUNKS=3, FIFO_DEPTH=2:
   - frame = {0x18,w0},{0x10,w1},{0x10,w2}, with no padding.
   - Back-to-back frames have zero-cycle gaps.
   - Pointer wrap is correct over 5 packets.

Source files
------------

// File: rtl/cpx_host_pkg.sv
// Shared constants for the CPX-to-host path: word/chunk widths and the
// header/padding values that frame each packet on the host stream.
package cpx_host_pkg;

   localparam int CPX_WORD_W = 32;
   localparam int CHUNK_W    = 64;

   localparam logic [31:0] CPX_HDR_FIRST = 32'h0000_0018;
   localparam logic [31:0] CPX_HDR_MID   = 32'h0000_0010;
   localparam logic [31:0] CPX_HDR_PAD   = 32'h0000_0000;
   localparam logic [31:0] CPX_PAD_WORD  = 32'h0BAD_0BAD;

endpackage

// File: rtl/cpx_pkt_serializer_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count and a
// combinational head read port. Push while full and pop while empty are
// ignored. DEPTH must be a power of two so the pointers wrap naturally.
module pkt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array is data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cpx_pkt_serializer.sv
// CPX-to-host serializer: buffers whole CPX packets and emits each one as a
// fixed-length frame of 64-bit {header, payload} chunks, one per chunk_read.
module cpx_pkt_serializer
   import cpx_host_pkg::*;
#(
   parameter int          PKT_WORDS    = 5,
   parameter int          FIFO_DEPTH   = 4,
   parameter int          FRAME_CHUNKS = 8,
   parameter logic [31:0] HDR_FIRST    = CPX_HDR_FIRST,
   parameter logic [31:0] HDR_MID      = CPX_HDR_MID,
   parameter logic [31:0] HDR_PAD      = CPX_HDR_PAD,
   parameter logic [31:0] PAD_WORD     = CPX_PAD_WORD
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              pkt_valid,
   output logic                              pkt_ready,
   input  logic [CPX_WORD_W*PKT_WORDS-1:0]   pkt_data,
   input  logic                              chunk_read,
   output logic [CHUNK_W-1:0]                chunk,
   output logic                              chunk_empty,
   output logic                              pkt_sent,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
   output logic [15:0]                       frames_sent
);

   localparam int PKT_W = CPX_WORD_W * PKT_WORDS;
   localparam int IDX_W = (FRAME_CHUNKS > 1) ? $clog2(FRAME_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_CHUNKS - 1);

   logic [PKT_W-1:0]      head;
   logic                  fifo_full;
   logic [IDX_W-1:0]      idx;
   logic                  advance;
   logic                  frame_done;
   logic [31:0]           hdr;
   logic [31:0]           word;

   // Ready depends only on registered occupancy, never on chunk_read.
   assign pkt_ready  = ~fifo_full;
   assign advance    = chunk_read & ~chunk_empty;
   assign frame_done = advance & (idx == IDX_LAST);

   pkt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PKT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pkt_valid),
      .pop   (frame_done),
      .din   (pkt_data),
      .head  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (chunk_empty)
   );

   // Chunk index within the current frame; wraps when the frame completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
      end else if (advance) begin
         idx <= frame_done ? '0 : idx + IDX_W'(1);
      end
   end

   // Frame-complete pulse and wrapping frame counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_sent    <= 1'b0;
         frames_sent <= '0;
      end else begin
         pkt_sent <= frame_done;
         if (frame_done) frames_sent <= frames_sent + 16'd1;
      end
   end

   // Chunk mux: payload word of the head packet, or padding past the packet
   // and whenever nothing is buffered.
   always_comb begin
      hdr  = HDR_PAD;
      word = PAD_WORD;
      if (!chunk_empty) begin
         for (int k = 0; k < PKT_WORDS; k++) begin
            if (int'(idx) == k) begin
               hdr  = (k == 0) ? HDR_FIRST : HDR_MID;
               word = head[PKT_W-1-CPX_WORD_W*k -: CPX_WORD_W];
            end
         end
      end
      chunk = {hdr, word};
   end

endmodule

// File: tb/tb_cpx_pkt_serializer.sv
// Self-checking bench for cpx_pkt_serializer: default configuration (5/8/4)
// and a no-padding configuration (3/3/2), checked against a chunk-stream model.
module tb_cpx_pkt_serializer;

   localparam int A_PW = 5, A_FC = 8, A_FD = 4;
   localparam int B_PW = 3, B_FC = 3, B_FD = 2;
   localparam logic [63:0] PAD_CHUNK = 64'h00000000_0BAD0BAD;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              a_pkt_valid, a_pkt_ready, a_chunk_read, a_chunk_empty, a_pkt_sent;
   logic [159:0]      a_pkt_data;
   logic [63:0]       a_chunk;
   logic [2:0]        a_fifo_count;
   logic [15:0]       a_frames_sent;

   logic              b_pkt_valid, b_pkt_ready, b_chunk_read, b_chunk_empty, b_pkt_sent;
   logic [95:0]       b_pkt_data;
   logic [63:0]       b_chunk;
   logic [1:0]        b_fifo_count;
   logic [15:0]       b_frames_sent;

   cpx_pkt_serializer dut_a (
      .clk(clk), .rst(rst), .pkt_valid(a_pkt_valid), .pkt_ready(a_pkt_ready),
      .pkt_data(a_pkt_data), .chunk_read(a_chunk_read), .chunk(a_chunk),
      .chunk_empty(a_chunk_empty), .pkt_sent(a_pkt_sent),
      .fifo_count(a_fifo_count), .frames_sent(a_frames_sent)
   );

   cpx_pkt_serializer #(.PKT_WORDS(B_PW), .FIFO_DEPTH(B_FD), .FRAME_CHUNKS(B_FC)) dut_b (
      .clk(clk), .rst(rst), .pkt_valid(b_pkt_valid), .pkt_ready(b_pkt_ready),
      .pkt_data(b_pkt_data), .chunk_read(b_chunk_read), .chunk(b_chunk),
      .chunk_empty(b_chunk_empty), .pkt_sent(b_pkt_sent),
      .fifo_count(b_fifo_count), .frames_sent(b_frames_sent)
   );

   int checks = 0;
   int errors = 0;

   // Model: the queue of chunks still owed to the host, in order.
   logic [63:0] qa[$];
   logic [63:0] qb[$];
   int          a_frames, b_frames;
   bit          a_sent, b_sent;

   logic [159:0] pkt_a_const = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
   logic [63:0]  tbl[8] = '{64'h00000018_11111111, 64'h00000010_22222222, 64'h00000010_33333333,
                            64'h00000010_44444444, 64'h00000010_55555555, 64'h00000000_0BAD0BAD,
                            64'h00000000_0BAD0BAD, 64'h00000000_0BAD0BAD};

   function automatic logic [159:0] rand_a();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [63:0] head_a();
      return (qa.size() != 0) ? qa[0] : PAD_CHUNK;
   endfunction

   function automatic logic [63:0] head_b();
      return (qb.size() != 0) ? qb[0] : PAD_CHUNK;
   endfunction

   // Drive one cycle on DUT A and advance the model using pre-edge state.
   task automatic drive_a(input bit v, input logic [159:0] d, input bit r);
      int cnt;
      a_pkt_valid = v; a_pkt_data = d; a_chunk_read = r;
      cnt = (qa.size() + A_FC - 1) / A_FC;
      a_sent = 0;
      if (r && qa.size() != 0) begin
         void'(qa.pop_front());
         if (qa.size() % A_FC == 0) begin
            a_sent = 1;
            a_frames = (a_frames + 1) % 65536;
         end
      end
      if (v && cnt != A_FD)
         for (int k = 0; k < A_FC; k++)
            qa.push_back(k == 0 ? {32'h00000018, d[159:128]} :
                         k < A_PW ? {32'h00000010, d[159-32*k -: 32]} : PAD_CHUNK);
      @(posedge clk); #1;
   endtask

   task automatic drive_b(input bit v, input logic [95:0] d, input bit r);
      int cnt;
      b_pkt_valid = v; b_pkt_data = d; b_chunk_read = r;
      cnt = (qb.size() + B_FC - 1) / B_FC;
      b_sent = 0;
      if (r && qb.size() != 0) begin
         void'(qb.pop_front());
         if (qb.size() % B_FC == 0) begin
            b_sent = 1;
            b_frames = (b_frames + 1) % 65536;
         end
      end
      if (v && cnt != B_FD)
         for (int k = 0; k < B_FC; k++)
            qb.push_back(k == 0 ? {32'h00000018, d[95:64]} : {32'h00000010, d[95-32*k -: 32]});
      @(posedge clk); #1;
   endtask

   task automatic apply_reset(input bit a_read);
      rst = 1'b1;
      a_pkt_valid = 0; a_pkt_data = '0; a_chunk_read = a_read;
      b_pkt_valid = 0; b_pkt_data = '0; b_chunk_read = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      a_chunk_read = 0;
      qa.delete(); qb.delete();
      a_frames = 0; b_frames = 0; a_sent = 0; b_sent = 0;
   endtask

   task automatic test_reset();
      apply_reset(0);
      apply_reset(0);
      checks++; if (a_pkt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a_pkt_ready); end
      checks++; if (a_chunk_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", a_chunk_empty); end
      checks++; if (a_fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", a_fifo_count); end
      checks++; if (a_frames_sent !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d want 0", a_frames_sent); end
      checks++; if (a_pkt_sent !== 1'b0) begin errors++; $display("FAIL reset_sent: got %b want 0", a_pkt_sent); end
      checks++; if (a_chunk !== PAD_CHUNK) begin errors++; $display("FAIL reset_chunk: got %h want %h", a_chunk, PAD_CHUNK); end
      checks++; if (b_chunk_empty !== 1'b1 || b_pkt_ready !== 1'b1) begin errors++; $display("FAIL reset_b: empty %b ready %b want 1 1", b_chunk_empty, b_pkt_ready); end
   endtask

   task automatic test_single_frame();
      drive_a(1, pkt_a_const, 0);
      for (int i = 0; i < A_FC; i++) begin
         checks++; if (a_chunk !== tbl[i] || a_chunk_empty !== 1'b0) begin errors++; $display("FAIL single_chunk%0d: got %h empty %b want %h", i, a_chunk, a_chunk_empty, tbl[i]); end
         drive_a(0, '0, 1);
         checks++; if (a_pkt_sent !== a_sent) begin errors++; $display("FAIL single_sent%0d: got %b want %b", i, a_pkt_sent, a_sent); end
      end
      checks++; if (a_pkt_sent !== 1'b1 || a_frames_sent !== 16'd1 || a_chunk_empty !== 1'b1) begin errors++; $display("FAIL single_end: sent %b frames %0d empty %b want 1 1 1", a_pkt_sent, a_frames_sent, a_chunk_empty); end
      drive_a(0, '0, 1);
      checks++; if (a_pkt_sent !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", a_pkt_sent); end
   endtask

   task automatic test_fill_drain();
      int pulses = 0;
      for (int i = 0; i < A_FD; i++) drive_a(1, rand_a(), 0);
      checks++; if (a_fifo_count !== 3'd4 || a_pkt_ready !== 1'b0) begin errors++; $display("FAIL fill_full: count %0d ready %b want 4 0", a_fifo_count, a_pkt_ready); end
      drive_a(1, rand_a(), 0);
      checks++; if (a_fifo_count !== 3'd4) begin errors++; $display("FAIL fill_drop: count %0d want 4", a_fifo_count); end
      for (int i = 0; i < 4 * A_FC; i++) begin
         checks++; if (a_chunk !== head_a() || a_chunk_empty !== 1'b0) begin errors++; $display("FAIL drain_chunk%0d: got %h want %h", i, a_chunk, head_a()); end
         drive_a(0, '0, 1);
         if (a_pkt_sent === 1'b1) pulses++;
         checks++; if (a_pkt_sent !== a_sent) begin errors++; $display("FAIL drain_sent%0d: got %b want %b", i, a_pkt_sent, a_sent); end
      end
      checks++; if (pulses != 4 || a_chunk_empty !== 1'b1) begin errors++; $display("FAIL drain_end: pulses %0d empty %b want 4 1", pulses, a_chunk_empty); end
      checks++; if (a_frames_sent !== 16'(a_frames)) begin errors++; $display("FAIL drain_frames: got %0d want %0d", a_frames_sent, a_frames); end
   endtask

   task automatic test_toggle_read();
      int n = 0;
      drive_a(1, pkt_a_const, 0);
      for (int i = 0; i < 2 * A_FC; i++) begin
         bit r = (i % 2 == 0);
         if (r) begin
            checks++; if (a_chunk !== tbl[n]) begin errors++; $display("FAIL toggle_chunk%0d: got %h want %h", n, a_chunk, tbl[n]); end
            n++;
         end else begin
            checks++; if (a_chunk !== head_a()) begin errors++; $display("FAIL toggle_hold%0d: got %h want %h", i, a_chunk, head_a()); end
         end
         drive_a(0, '0, r);
      end
      checks++; if (a_chunk_empty !== 1'b1 || a_frames_sent !== 16'(a_frames)) begin errors++; $display("FAIL toggle_end: empty %b frames %0d want 1 %0d", a_chunk_empty, a_frames_sent, a_frames); end
   endtask

   task automatic test_full_pop();
      logic [159:0] p5 = rand_a();
      for (int i = 0; i < A_FD; i++) drive_a(1, rand_a(), 0);
      for (int i = 0; i < A_FC - 1; i++) drive_a(0, '0, 1);
      checks++; if (a_fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_before: count %0d want 4", a_fifo_count); end
      drive_a(1, p5, 1);
      checks++; if (a_fifo_count !== 3'd3 || a_pkt_ready !== 1'b1 || a_pkt_sent !== 1'b1) begin errors++; $display("FAIL fullpop_pop: count %0d ready %b sent %b want 3 1 1", a_fifo_count, a_pkt_ready, a_pkt_sent); end
      drive_a(1, p5, 0);
      checks++; if (a_fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_push: count %0d want 4", a_fifo_count); end
      for (int i = 0; i < 4 * A_FC; i++) begin
         checks++; if (a_chunk !== head_a()) begin errors++; $display("FAIL fullpop_chunk%0d: got %h want %h", i, a_chunk, head_a()); end
         drive_a(0, '0, 1);
      end
      checks++; if (a_chunk_empty !== 1'b1) begin errors++; $display("FAIL fullpop_end: empty %b want 1", a_chunk_empty); end
   endtask

   task automatic test_reset_mid_frame();
      logic [159:0] np = rand_a();
      drive_a(1, rand_a(), 0);
      drive_a(1, rand_a(), 0);
      for (int i = 0; i < 3; i++) drive_a(0, '0, 1);
      apply_reset(1);
      checks++; if (a_fifo_count !== 3'd0 || a_chunk_empty !== 1'b1 || a_pkt_sent !== 1'b0) begin errors++; $display("FAIL midreset: count %0d empty %b sent %b want 0 1 0", a_fifo_count, a_chunk_empty, a_pkt_sent); end
      drive_a(1, np, 0);
      checks++; if (a_chunk !== {32'h00000018, np[159:128]}) begin errors++; $display("FAIL midreset_first: got %h want %h", a_chunk, {32'h00000018, np[159:128]}); end
      for (int i = 0; i < A_FC; i++) begin
         checks++; if (a_chunk !== head_a()) begin errors++; $display("FAIL midreset_chunk%0d: got %h want %h", i, a_chunk, head_a()); end
         drive_a(0, '0, 1);
      end
   endtask

   task automatic test_random_traffic();
      for (int i = 0; i < 400; i++) begin
         drive_a(($urandom % 3) == 0, rand_a(), ($urandom % 4) != 0);
         checks++;
         if (a_chunk !== head_a() || a_chunk_empty !== (qa.size() == 0) || a_pkt_sent !== a_sent ||
             a_fifo_count !== 3'((qa.size() + A_FC - 1) / A_FC) || a_pkt_ready !== (a_fifo_count != 3'd4) ||
             a_frames_sent !== 16'(a_frames)) begin
            errors++;
            $display("FAIL random%0d: chunk %h empty %b sent %b count %0d frames %0d want %h %b %b %0d %0d", i,
                     a_chunk, a_chunk_empty, a_pkt_sent, a_fifo_count, a_frames_sent,
                     head_a(), qa.size() == 0, a_sent, (qa.size() + A_FC - 1) / A_FC, a_frames);
         end
      end
   endtask

   task automatic test_back_to_back_small();
      logic [31:0] hdrs[3] = '{32'h00000018, 32'h00000010, 32'h00000010};
      int tries = 0;
      drive_b(1, {$urandom, $urandom, $urandom}, 0);
      drive_b(1, {$urandom, $urandom, $urandom}, 0);
      checks++; if (b_fifo_count !== 2'd2 || b_pkt_ready !== 1'b0) begin errors++; $display("FAIL small_full: count %0d ready %b want 2 0", b_fifo_count, b_pkt_ready); end
      for (int i = 0; i < 2 * B_FC; i++) begin
         checks++; if (b_chunk_empty !== 1'b0 || b_chunk[63:32] !== hdrs[i % 3] || b_chunk !== head_b()) begin errors++; $display("FAIL small_b2b%0d: got %h empty %b want %h", i, b_chunk, b_chunk_empty, head_b()); end
         drive_b(0, '0, 1);
      end
      checks++; if (b_chunk_empty !== 1'b1 || b_frames_sent !== 16'd2) begin errors++; $display("FAIL small_b2b_end: empty %b frames %0d want 1 2", b_chunk_empty, b_frames_sent); end
      while ((qb.size() != 0 || b_frames < 7) && tries < 60) begin
         checks++; if (b_chunk !== head_b() || b_chunk_empty !== (qb.size() == 0)) begin errors++; $display("FAIL small_wrap%0d: got %h want %h", tries, b_chunk, head_b()); end
         drive_b(b_frames < 6, {$urandom, $urandom, $urandom}, 1);
         checks++; if (b_pkt_sent !== b_sent || b_fifo_count !== 2'((qb.size() + B_FC - 1) / B_FC)) begin errors++; $display("FAIL small_state%0d: sent %b count %0d want %b %0d", tries, b_pkt_sent, b_fifo_count, b_sent, (qb.size() + B_FC - 1) / B_FC); end
         tries++;
      end
      checks++; if (tries >= 60 || b_frames_sent !== 16'(b_frames)) begin errors++; $display("FAIL small_done: tries %0d frames %0d want <60 %0d", tries, b_frames_sent, b_frames); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_fill_drain();
      test_toggle_read();
      test_full_pop();
      test_reset_mid_frame();
      test_random_traffic();
      test_back_to_back_small();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
